// File: rtl/mem_arbiter_n.sv
// N-port 256-bit block arbiter between L1 requesters and L2, one L2 transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, port 0 highest.
module mem_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 256,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          port_read,
  input  logic [NUM_PORTS-1:0]          port_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_address,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  output logic [DATA_W-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]          port_resp,
  output logic                          l2_read,
  output logic                          l2_write,
  output logic [ADDR_W-1:0]             l2_address,
  output logic [DATA_W-1:0]             l2_wdata,
  input  logic                          l2_resp,
  input  logic [DATA_W-1:0]             l2_rdata,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q;
  logic [NUM_PORTS-1:0]   req_s;
  logic [NUM_PORTS-1:0]   resp_onehot_s;
  logic [NUM_PORTS-1:0]   port_resp_q;
  logic                   any_req_s;
  logic [IDX_W-1:0]       winner_s;
  logic [IDX_W-1:0]       grant_idx_q;
  logic                   win_wr_s;
  logic [ADDR_W-1:0]      win_addr_s;
  logic [DATA_W-1:0]      win_wdata_s;
  logic [ADDR_W-1:0]      l2_address_q;
  logic [DATA_W-1:0]      l2_wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   l2_read_q;
  logic                   l2_write_q;
  logic                   busy_q;

  assign req_s     = port_read | port_write;
  assign any_req_s = |req_s;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W:0]   cand_s;

  // Scan downward from pointer+N-1 so the candidate closest to the pointer is assigned last.
  always_comb begin
    winner_s = '0;
    cand_s   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand_s   = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      cand_s   = (cand_s >= (IDX_W+1)'(NUM_PORTS)) ? cand_s - (IDX_W+1)'(NUM_PORTS) : cand_s;
      winner_s = req_s[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : winner_s;
    end
  end

  // Pointer moves just past the winner on each grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (state_q == IDLE && any_req_s) begin
      rr_ptr_q <= (winner_s == IDX_W'(NUM_PORTS - 1)) ? '0 : winner_s + IDX_W'(1);
    end
  end
`else
  // Lowest requesting index wins.
  always_comb begin
    winner_s = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      winner_s = req_s[k] ? IDX_W'(k) : winner_s;
    end
  end
`endif

  // Steer the winning port's fields; a port with read and write both set is a write.
  always_comb begin
    win_wr_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (winner_s == IDX_W'(k)) begin
        win_wr_s    = port_write[k];
        win_addr_s  = port_address[k*ADDR_W +: ADDR_W];
        win_wdata_s = port_wdata[k*DATA_W +: DATA_W];
      end else begin
        win_wr_s    = win_wr_s;
      end
    end
  end

  assign resp_onehot_s = NUM_PORTS'(1) << grant_idx_q;

  // Transaction FSM; every output is a register written only here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      port_resp_q  <= '0;
      grant_idx_q  <= '0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
      rdata_q      <= '0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          port_resp_q <= '0;
          if (any_req_s) begin
            grant_idx_q  <= winner_s;
            l2_address_q <= win_addr_s;
            if (win_wr_s) begin
              l2_wdata_q <= win_wdata_s;
            end
            l2_write_q   <= win_wr_s;
            l2_read_q    <= ~win_wr_s;
            busy_q       <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (l2_resp) begin
            if (l2_read_q) begin
              rdata_q <= l2_rdata;
            end
            l2_read_q   <= 1'b0;
            l2_write_q  <= 1'b0;
            port_resp_q <= resp_onehot_s;
            state_q     <= RESP;
          end
        end
        RESP: begin
          port_resp_q <= '0;
          busy_q      <= 1'b0;
          grant_idx_q <= '0;
          state_q     <= IDLE;
        end
        default: begin
          port_resp_q <= '0;
          l2_read_q   <= 1'b0;
          l2_write_q  <= 1'b0;
          busy_q      <= 1'b0;
          grant_idx_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign port_rdata = rdata_q;
  assign port_resp  = port_resp_q;
  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;
  assign busy       = busy_q;
  assign grant_idx  = grant_idx_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Self-checking bench for mem_arbiter_n with three ports; expectations queued on drive, popped on response.
module tb_mem_arbiter_n;

  localparam int NP = 3;
  localparam int AW = 16;
  localparam int DW = 256;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     port_read;
  logic [NP-1:0]     port_write;
  logic [NP*AW-1:0]  port_address;
  logic [NP*DW-1:0]  port_wdata;
  logic [DW-1:0]     port_rdata;
  logic [NP-1:0]     port_resp;
  logic              l2_read;
  logic              l2_write;
  logic [AW-1:0]     l2_address;
  logic [DW-1:0]     l2_wdata;
  logic              l2_resp;
  logic [DW-1:0]     l2_rdata;
  logic              busy;
  logic [IW-1:0]     grant_idx;

  mem_arbiter_n #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_resp(port_resp),
    .l2_read(l2_read), .l2_write(l2_write),
    .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb_q[$];
  int            grant_q[$];
  logic [DW-1:0] model_rdata;
  int            tests_run = 0;
  int            tests_failed = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_txn(input int p, input bit rd, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] l2d, input int lat,
                        input bit drop, input string name);
    exp_t          e;
    int            n;
    logic [1:0]    exp_op;
    logic [NP-1:0] exp_resp;
    exp_op = wr ? 2'b10 : 2'b01;
    @(negedge clk);
    port_read[p]  = rd;
    port_write[p] = wr;
    port_address[p*AW +: AW] = addr;
    port_wdata[p*DW +: DW]   = wd;
    e.port  = p;
    e.rdata = wr ? model_rdata : l2d;
    model_rdata = e.rdata;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(l2_read || l2_write) && n < 20);
    tests_run++;
    if (n !== 1) begin
      tests_failed++; $display("FAIL %s l2_start_cycle: got %0d want 1", name, n);
    end
    tests_run++;
    if ({l2_write, l2_read} !== exp_op) begin
      tests_failed++; $display("FAIL %s l2_op: got %b want %b", name, {l2_write, l2_read}, exp_op);
    end
    tests_run++;
    if (l2_address !== addr) begin
      tests_failed++; $display("FAIL %s l2_address: got %h want %h", name, l2_address, addr);
    end
    if (wr) begin
      tests_run++;
      if (l2_wdata !== wd) begin
        tests_failed++; $display("FAIL %s l2_wdata: got %h want %h", name, l2_wdata, wd);
      end
    end
    tests_run++;
    if (grant_idx !== IW'(p) || busy !== 1'b1) begin
      tests_failed++; $display("FAIL %s grant_busy: got idx=%0d busy=%b want idx=%0d busy=1", name, grant_idx, busy, p);
    end
    if (drop) begin
      port_read[p]  = 1'b0;
      port_write[p] = 1'b0;
    end
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      tests_run++;
      if ({l2_write, l2_read} !== exp_op || l2_address !== addr || port_resp !== '0) begin
        tests_failed++;
        $display("FAIL %s l2_hold cycle %0d: got op=%b addr=%h resp=%b want op=%b addr=%h resp=0",
                 name, c + 1, {l2_write, l2_read}, l2_address, port_resp, exp_op, addr);
      end
    end
    l2_rdata = l2d;
    l2_resp  = 1'b1;
    @(negedge clk);
    l2_resp  = 1'b0;
    e = sb_q.pop_front();
    exp_resp = NP'(1) << e.port;
    tests_run++;
    if (port_resp !== exp_resp) begin
      tests_failed++; $display("FAIL %s port_resp: got %b want %b", name, port_resp, exp_resp);
    end
    tests_run++;
    if (port_rdata !== e.rdata) begin
      tests_failed++; $display("FAIL %s port_rdata: got %h want %h", name, port_rdata, e.rdata);
    end
    tests_run++;
    if ({l2_write, l2_read} !== 2'b00) begin
      tests_failed++; $display("FAIL %s l2_clear: got %b want 00", name, {l2_write, l2_read});
    end
    port_read[p]  = 1'b0;
    port_write[p] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (port_resp !== '0 || busy !== 1'b0 || grant_idx !== '0) begin
      tests_failed++;
      $display("FAIL %s idle_after: got resp=%b busy=%b idx=%0d want 0/0/0", name, port_resp, busy, grant_idx);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    port_read    = '0;
    port_write   = '0;
    port_address = '0;
    port_wdata   = '0;
    l2_resp      = 1'b0;
    l2_rdata     = '0;
    model_rdata  = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({port_resp, l2_read, l2_write, busy, grant_idx} !== '0 || port_rdata !== '0 ||
        l2_address !== '0 || l2_wdata !== '0) begin
      tests_failed++; $display("FAIL reset_state: outputs not all zero (resp=%b busy=%b)", port_resp, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_txn(0, 1'b1, 1'b0, 16'h1234, '0, {32{8'hA5}}, 4, 1'b0, "single_read");
  endtask

  task automatic test_write();
    do_txn(1, 1'b0, 1'b1, 16'h8000, {32{8'h0F}}, {32{8'h3C}}, 2, 1'b0, "write");
  endtask

  task automatic test_reset_mid_busy();
    int n;
    @(negedge clk);
    port_read[1] = 1'b1;
    port_address[1*AW +: AW] = 16'h2222;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!l2_read && n < 20);
    tests_run++;
    if (l2_read !== 1'b1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL rst_busy_pre: got l2_read=%b busy=%b want 1/1", l2_read, busy);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({port_resp, l2_read, l2_write, busy, grant_idx} !== '0 || port_rdata !== '0 ||
        l2_address !== '0 || l2_wdata !== '0) begin
      tests_failed++;
      $display("FAIL rst_async: got read=%b busy=%b addr=%h rdata=%h want all 0", l2_read, busy, l2_address, port_rdata);
    end
    port_read   = '0;
    model_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    do_txn(1, 1'b1, 1'b0, 16'h2222, '0, {32{8'h5A}}, 2, 1'b0, "after_reset");
  endtask

  task automatic test_rw_both();
    do_txn(0, 1'b1, 1'b1, 16'h0040, {32{8'hC3}}, {32{8'h99}}, 1, 1'b0, "rw_both");
  endtask

  task automatic test_spurious_drop();
    @(negedge clk);
    l2_rdata = {32{8'hEE}};
    l2_resp  = 1'b1;
    @(negedge clk);
    l2_resp  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tests_run++;
      if (port_resp !== '0 || busy !== 1'b0 || port_rdata !== model_rdata) begin
        tests_failed++;
        $display("FAIL spurious_idle: got resp=%b busy=%b rdata=%h want 0/0/%h", port_resp, busy, port_rdata, model_rdata);
      end
      @(negedge clk);
    end
    do_txn(2, 1'b1, 1'b0, 16'h0100, '0, {32{8'h77}}, 3, 1'b1, "dropped_req");
  endtask

  task automatic test_arbitration();
    int n;
    int exp_g;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_RR_EN
      grant_q.push_back(g % NP);
`else
      grant_q.push_back(0);
`endif
    end
    port_read = '1;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!l2_read && n < 20);
      exp_g = grant_q.pop_front();
      tests_run++;
      if (grant_idx !== IW'(exp_g) || l2_read !== 1'b1) begin
        tests_failed++; $display("FAIL arb_grant %0d: got idx=%0d read=%b want idx=%0d", g, grant_idx, l2_read, exp_g);
      end
      l2_resp = 1'b1;
      @(negedge clk);
      l2_resp = 1'b0;
      tests_run++;
      if (port_resp !== (NP'(1) << exp_g)) begin
        tests_failed++; $display("FAIL arb_resp %0d: got %b want %b", g, port_resp, NP'(1) << exp_g);
      end
    end
    port_read = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || port_resp !== '0) begin
      tests_failed++; $display("FAIL arb_idle: got busy=%b resp=%b want 0/0", busy, port_resp);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_reset_mid_busy();
    test_rw_both();
    test_spurious_drop();
    test_arbitration();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
